// File: rtl/lcd_rx_model.sv
// HD44780-style LCD responder: decodes the 4-bit e/rs/rw/db write bus into instructions and an 80-byte DDRAM.
// Optional LCD_RX_READBACK_EN adds the rw=1 status read-back (db_out/db_oe).
module lcd_rx_model #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  CLEAR_FILL  = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_db,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor_idx,
    output logic       mode4,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_dir,
    output logic       busy,
    output logic       ovf
`ifdef LCD_RX_READBACK_EN
    ,
    output logic [3:0] db_out,
    output logic       db_oe
`endif
);
    localparam int         DEPTH = 80;
    localparam logic [6:0] LAST  = 7'(DEPTH - 1);

    typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} state_t;

    state_t                       state, state_next;
    logic [SYNC_STAGES-1:0][6:0]  bus_sync;
    logic                         e_d;
    logic                         e_s, rs_s, rw_s;
    logic [3:0]                   db_s;
    logic                         strobe, wr_strobe, accept;
    logic [3:0]                   hi_nib;
    logic                         load_hi, exec_req, exec_rs_n;
    logic [7:0]                   exec_byte_n;
    logic                         exec_pend, exec_rs;
    logic [7:0]                   exec_byte;
    logic [6:0]                   idx, clr_cnt;
    logic [7:0]                   mem [DEPTH];
    logic                         mem_we;
    logic [6:0]                   mem_wa;
    logic [7:0]                   mem_wd;

    function automatic logic [6:0] idx_step(input logic [6:0] i, input logic up);
        if (up) return (i == LAST) ? 7'd0 : i + 7'd1;
        else    return (i == 7'd0) ? LAST : i - 7'd1;
    endfunction

    // Two 40-cell lines: 0x00-0x27 and 0x40-0x67 map onto one contiguous 0-79 index.
    function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
        if (a <= 7'h27)                    return a;
        else if (a >= 7'h40 && a <= 7'h67) return a - 7'h18;
        else                               return 7'd0;
    endfunction

    assign e_s  = bus_sync[SYNC_STAGES-1][6];
    assign rs_s = bus_sync[SYNC_STAGES-1][5];
    assign rw_s = bus_sync[SYNC_STAGES-1][4];
    assign db_s = bus_sync[SYNC_STAGES-1][3:0];

    assign strobe    = e_d & ~e_s;
    assign wr_strobe = strobe & ~rw_s;
    assign accept    = wr_strobe & ~busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_sync <= '0;
            e_d      <= 1'b0;
        end else begin
            bus_sync[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_db};
            for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
            e_d <= e_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT8;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        load_hi     = 1'b0;
        exec_req    = 1'b0;
        exec_rs_n   = 1'b0;
        exec_byte_n = {hi_nib, db_s};
        case (state)
            INIT8: if (accept) begin
                if (db_s == 4'h2) state_next = NIB_HI;
                else if (db_s != 4'h3) begin
                    exec_req    = 1'b1;
                    exec_byte_n = {db_s, 4'h0};
                end
            end
            NIB_HI: if (accept) begin
                load_hi    = 1'b1;
                state_next = NIB_LO;
            end
            NIB_LO: if (accept) begin
                exec_req   = 1'b1;
                exec_rs_n  = rs_s;
                state_next = NIB_HI;
            end
            default: state_next = INIT8;
        endcase
        // Function set with DL=1 drops back to 8-bit mode.
        if (exec_pend && !exec_rs && exec_byte[7:5] == 3'b001 && exec_byte[4])
            state_next = INIT8;
    end

    assign mode4      = (state != INIT8);
    assign cursor_idx = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_nib    <= 4'h0;
            exec_pend <= 1'b0;
            exec_rs   <= 1'b0;
            exec_byte <= 8'h00;
            idx       <= 7'd0;
            clr_cnt   <= 7'd0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            inc_dir   <= 1'b1;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (load_hi) hi_nib <= db_s;
            exec_pend <= exec_req;
            if (exec_req) begin
                exec_byte <= exec_byte_n;
                exec_rs   <= exec_rs_n;
            end
            if (wr_strobe && busy) ovf <= 1'b1;

            if (busy) begin
                if (clr_cnt == LAST) begin
                    busy    <= 1'b0;
                    idx     <= 7'd0;
                    inc_dir <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + 7'd1;
                end
            end else if (exec_pend) begin
                if (exec_rs) begin
                    idx <= idx_step(idx, inc_dir);
                end else begin
                    casez (exec_byte)
                        8'b1???????: idx <= addr_to_idx(exec_byte[6:0]);
                        8'b0001????: if (!exec_byte[3]) idx <= idx_step(idx, exec_byte[2]);
                        8'b00001???: begin
                            disp_on   <= exec_byte[2];
                            cursor_on <= exec_byte[1];
                            blink_on  <= exec_byte[0];
                        end
                        8'b000001??: inc_dir <= exec_byte[1];
                        8'b0000001?: idx <= 7'd0;
                        8'b00000001: begin
                            busy    <= 1'b1;
                            clr_cnt <= 7'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // The clear sweep and data writes never overlap: data only executes while idle.
    assign mem_we = busy | (exec_pend & exec_rs);
    assign mem_wa = busy ? clr_cnt : idx;
    assign mem_wd = busy ? CLEAR_FILL : exec_byte;

    // NOTE: DDRAM is deliberately left out of reset so it maps onto block RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rd_data <= 8'h00;
        else if (rd_addr <= LAST)  rd_data <= mem[rd_addr];
        else                       rd_data <= 8'h00;
    end

`ifdef LCD_RX_READBACK_EN
    logic rd_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               rd_phase <= 1'b0;
        else if (strobe && rw_s)  rd_phase <= ~rd_phase;
    end

    assign db_oe  = rw_s & e_s;
    assign db_out = rd_phase ? idx[3:0] : {busy, idx[6:4]};
`endif

endmodule

// File: tb/tb_lcd_rx_model.sv
// Scoreboard bench for lcd_rx_model: stimulus pushes expectations, a monitor compares DUT outputs.
module tb_lcd_rx_model;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [3:0] lcd_db = 4'h0;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] rd_data;
    logic [6:0] cursor_idx;
    logic       mode4, disp_on, cursor_on, blink_on, inc_dir, busy, ovf;
`ifdef LCD_RX_READBACK_EN
    logic [3:0] db_out;
    logic       db_oe;
`endif

    lcd_rx_model #(.SYNC_STAGES(2), .CLEAR_FILL(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_db(lcd_db), .rd_addr(rd_addr), .rd_data(rd_data), .cursor_idx(cursor_idx),
        .mode4(mode4), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .inc_dir(inc_dir), .busy(busy), .ovf(ovf)
`ifdef LCD_RX_READBACK_EN
        , .db_out(db_out), .db_oe(db_oe)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t rd_q[$], st_q[$], bz_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_req = 1'b0, st_req = 1'b0;
    logic rd_req_d = 1'b0, st_req_d = 1'b0;
    int   bz_cnt = 0;
    logic [13:0] st_act;

    assign st_act = {mode4, disp_on, cursor_on, blink_on, inc_dir, busy, ovf, cursor_idx};

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Request flags are registered so the monitor compares one cycle after issue.
    always @(posedge clk) begin
        rd_req_d <= rd_req;
        st_req_d <= st_req;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_req_d) begin
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_q underflow at %0t", $time);
                end else begin
                    e = rd_q.pop_front();
                    check(e.name, {8'h00, rd_data}, e.val);
                end
            end
            if (st_req_d) begin
                if (st_q.size() == 0) begin
                    errors++;
                    $display("FAIL st_q underflow at %0t", $time);
                end else begin
                    e = st_q.pop_front();
                    check(e.name, {2'b00, st_act}, e.val);
                end
            end
            if (!rst_n) begin
                bz_cnt = 0;
            end else if (busy) begin
                bz_cnt++;
            end else if (bz_cnt > 0) begin
                if (bz_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected busy pulse of %0d cycles at %0t", bz_cnt, $time);
                end else begin
                    e = bz_q.pop_front();
                    check(e.name, 16'(bz_cnt), e.val);
                end
                bz_cnt = 0;
            end
        end
    end

    task automatic expect_rd(input string name, input logic [6:0] a, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.val  = {8'h00, v};
        @(negedge clk);
        rd_addr = a;
        rd_req  = 1'b1;
        rd_q.push_back(e);
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic expect_st(input string name, input logic m4, input logic d, input logic c,
                             input logic b, input logic i, input logic bs, input logic ov,
                             input logic [6:0] ix);
        exp_t e;
        e.name = name;
        e.val  = {2'b00, m4, d, c, b, i, bs, ov, ix};
        @(negedge clk);
        st_req = 1'b1;
        st_q.push_back(e);
        @(negedge clk);
        st_req = 1'b0;
    endtask

    task automatic expect_busy(input string name, input int len);
        exp_t e;
        e.name = name;
        e.val  = 16'(len);
        bz_q.push_back(e);
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
        @(negedge clk);
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_db = d;
        lcd_e  = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wr(input logic rs, input logic [7:0] b);
        strobe(rs, 1'b0, b[7:4]);
        strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, {15'd0, busy}, 16'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic init_seq();
        strobe(1'b0, 1'b0, 4'h3);
        strobe(1'b0, 1'b0, 4'h3);
        strobe(1'b0, 1'b0, 4'h3);
    endtask

`ifdef LCD_RX_READBACK_EN
    task automatic read_strobe(input string name, input logic [3:0] exp_nib);
        @(negedge clk);
        lcd_rw = 1'b1;
        lcd_db = 4'h0;
        lcd_e  = 1'b1;
        repeat (4) @(negedge clk);
        check({name, "_oe_hi"}, {15'd0, db_oe}, 16'd1);
        check({name, "_db"}, {12'd0, db_out}, {12'd0, exp_nib});
        lcd_e = 1'b0;
        repeat (8) @(negedge clk);
        check({name, "_oe_lo"}, {15'd0, db_oe}, 16'd0);
        lcd_rw = 1'b0;
    endtask
`endif

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        expect_st("reset_state", 0, 0, 0, 0, 1, 0, 0, 7'd0);
        expect_rd("reset_rd_data", 7'd5, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        init_seq();
        expect_st("init_after_333", 0, 0, 0, 0, 1, 0, 0, 7'd0);
        strobe(1'b0, 1'b0, 4'h2);
        expect_st("init_mode4", 1, 0, 0, 0, 1, 0, 0, 7'd0);

        wr(1'b0, 8'h28);
        wr(1'b0, 8'h06);
        wr(1'b0, 8'h0F);
        expect_st("disp_dcb_all", 1, 1, 1, 1, 1, 0, 0, 7'd0);
        wr(1'b0, 8'h0C);
        expect_st("disp_on_only", 1, 1, 0, 0, 1, 0, 0, 7'd0);

        expect_busy("clear1_busy_len", 80);
        wr(1'b0, 8'h01);
        wait_idle("clear1_done");
        for (int i = 0; i < 80; i++) expect_rd($sformatf("clear1_fill_%0d", i), 7'(i), 8'h20);
        expect_rd("rd_oob_80", 7'd80, 8'h00);
        expect_rd("rd_oob_127", 7'd127, 8'h00);

        wr(1'b1, 8'h48);
        wr(1'b1, 8'h65);
        expect_rd("data_0", 7'd0, 8'h48);
        expect_rd("data_1", 7'd1, 8'h65);
        expect_st("data_idx2", 1, 1, 0, 0, 1, 0, 0, 7'd2);

        wr(1'b0, 8'hA7);
        wr(1'b1, 8'h41);
        expect_rd("addr27_data", 7'd39, 8'h41);
        expect_st("addr27_idx40", 1, 1, 0, 0, 1, 0, 0, 7'd40);
        wr(1'b0, 8'hC0);
        expect_st("addr40_idx", 1, 1, 0, 0, 1, 0, 0, 7'd40);
        wr(1'b0, 8'hB0);
        expect_st("addr_illegal", 1, 1, 0, 0, 1, 0, 0, 7'd0);

        wr(1'b0, 8'h04);
        wr(1'b1, 8'h5A);
        expect_rd("dec_wrap_data", 7'd0, 8'h5A);
        expect_st("dec_wrap_idx", 1, 1, 0, 0, 0, 0, 0, 7'd79);
        wr(1'b0, 8'h06);
        wr(1'b0, 8'hE7);
        wr(1'b1, 8'h33);
        expect_rd("inc_wrap_data", 7'd79, 8'h33);
        expect_st("inc_wrap_idx", 1, 1, 0, 0, 1, 0, 0, 7'd0);

        wr(1'b0, 8'h14);
        expect_st("shift_right", 1, 1, 0, 0, 1, 0, 0, 7'd1);
        wr(1'b0, 8'h10);
        wr(1'b0, 8'h10);
        expect_st("shift_left_wrap", 1, 1, 0, 0, 1, 0, 0, 7'd79);
        wr(1'b0, 8'h18);
        expect_st("display_shift_ign", 1, 1, 0, 0, 1, 0, 0, 7'd79);
        wr(1'b0, 8'h02);
        expect_st("home", 1, 1, 0, 0, 1, 0, 0, 7'd0);

        expect_busy("clear2_busy_len", 80);
        wr(1'b0, 8'h01);
        wr(1'b1, 8'h77);
        wait_idle("clear2_done");
        expect_st("overrun_ovf", 1, 1, 0, 0, 1, 0, 1, 7'd0);
        expect_rd("overrun_rd0", 7'd0, 8'h20);
        expect_rd("overrun_rd39", 7'd39, 8'h20);
        expect_rd("overrun_rd79", 7'd79, 8'h20);
        wr(1'b1, 8'h41);
        expect_rd("overrun_phase", 7'd0, 8'h41);
        expect_st("overrun_idx1", 1, 1, 0, 0, 1, 0, 1, 7'd1);

        wr(1'b0, 8'hE7);
        wr(1'b1, 8'h7E);
        expect_rd("pre_reset_79", 7'd79, 8'h7E);
        wr(1'b0, 8'h01);
        for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midclr_busy", {15'd0, busy}, 16'd0);
        check("midclr_ovf", {15'd0, ovf}, 16'd0);
        expect_st("midclr_reset_state", 0, 0, 0, 0, 1, 0, 0, 7'd0);
        rst_n = 1'b1;
        expect_rd("midclr_keep79", 7'd79, 8'h7E);
        expect_rd("midclr_clr0", 7'd0, 8'h20);

        init_seq();
        strobe(1'b0, 1'b0, 4'h2);
        wr(1'b0, 8'hDD);
`ifdef LCD_RX_READBACK_EN
        read_strobe("rb_first", 4'h4);
        read_strobe("rb_second", 4'h5);
`else
        strobe(1'b0, 1'b1, 4'h0);
        strobe(1'b0, 1'b1, 4'h0);
`endif
        wr(1'b1, 8'h21);
        expect_rd("rw_skip_data", 7'd69, 8'h21);
        expect_st("rw_skip_idx", 1, 0, 0, 0, 1, 0, 0, 7'd70);

        repeat (3) @(negedge clk);
        check("sb_drained", 16'(rd_q.size() + st_q.size() + bz_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
